wavefront_deskew: RTL and testbench

Output-side counterpart of the input skew stage: takes the five staggered result lanes leaving the systolic array, where lane k trails lane 0 by k·WAVEFRONT_DELAY cycles, and delays each lane by (4−k)·WAVEFRONT_DELAY so all five leave in the same cycle. Sits between the array's output edge and the pooling/writeback logic. It also counts aligned beats into frames and flags lane valids that break the expected skew.

---
 rtl/wavefront_deskew_pkg.sv | 31 +++
 rtl/wavefront_deskew_lane_delay_line.sv | 62 ++++++
 rtl/wavefront_deskew.sv | 124 ++++++++++++
 tb/tb_wavefront_deskew.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/wavefront_deskew_pkg.sv
// Shared lane constants, alignment classification and per-lane delay depth
// for the systolic-array output deskew stage.
package wavefront_deskew_pkg;

  localparam int NUM_LANES = 5;
  localparam int LAST_LANE = NUM_LANES - 1;

  typedef logic [2:0] lane_idx_t;

  typedef enum logic [1:0] {
    ALIGN_IDLE = 2'd0,
    ALIGN_BEAT = 2'd1,
    ALIGN_SKEW = 2'd2
  } align_e;

  // Lane k trails lane 0 by k steps, so it needs the complementary delay.
  function automatic int lane_depth(input lane_idx_t lane, input int wavefront_delay);
    return (LAST_LANE - int'(lane)) * wavefront_delay;
  endfunction

  function automatic align_e classify(input logic [NUM_LANES-1:0] vld);
    if (&vld) begin
      return ALIGN_BEAT;
    end
    if (vld == '0) begin
      return ALIGN_IDLE;
    end
    return ALIGN_SKEW;
  endfunction

endpackage

// File: rtl/wavefront_deskew_lane_delay_line.sv
// Fixed-depth valid+data shift chain, latency DEPTH cycles (0 = wire).
// No backpressure: shifts every cycle; chain_busy reports any valid stage.
module lane_delay_line #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_vld,
  input  logic [DATA_WIDTH-1:0] in_dat,
  output logic                  out_vld,
  output logic [DATA_WIDTH-1:0] out_dat,
  output logic                  chain_busy
);

  localparam int W = DATA_WIDTH + 1;

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = ^{clk, rst_n};
      assign out_vld        = in_vld;
      assign out_dat        = in_dat;
      assign chain_busy     = 1'b0;
    end else begin : g_chain
      logic [W-1:0]     chain_q [DEPTH];
      logic [W-1:0]     chain_d [DEPTH];
      logic [DEPTH-1:0] stage_vld;

      always_comb begin
        chain_d[0] = {in_vld, in_dat};
        for (int i = 1; i < DEPTH; i++) begin
          chain_d[i] = chain_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            chain_q[i] <= '0;
          end
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            chain_q[i] <= chain_d[i];
          end
        end
      end

      always_comb begin
        stage_vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
          stage_vld[i] = chain_q[i][W-1];
        end
      end

      assign out_vld    = chain_q[DEPTH-1][W-1];
      assign out_dat    = chain_q[DEPTH-1][DATA_WIDTH-1:0];
      assign chain_busy = |stage_vld;
    end
  endgenerate

endmodule

// File: rtl/wavefront_deskew.sv
// Realigns five staggered systolic output lanes, latency (4-k)*WAVEFRONT_DELAY+1 for lane k.
// No backpressure: one aligned beat per cycle; mixed lane valids drop the beat and flag skew_err.
module wavefront_deskew
  import wavefront_deskew_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int WAVEFRONT_DELAY = 4,
  parameter int FRAME_LEN       = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4:0]            lane_valid_in,
  input  logic [DATA_WIDTH-1:0] line_0_in,
  input  logic [DATA_WIDTH-1:0] line_1_in,
  input  logic [DATA_WIDTH-1:0] line_2_in,
  input  logic [DATA_WIDTH-1:0] line_3_in,
  input  logic [DATA_WIDTH-1:0] line_4_in,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] line_0_out,
  output logic [DATA_WIDTH-1:0] line_1_out,
  output logic [DATA_WIDTH-1:0] line_2_out,
  output logic [DATA_WIDTH-1:0] line_3_out,
  output logic [DATA_WIDTH-1:0] line_4_out,
  output logic                  out_valid,
  output logic                  frame_last,
  output logic                  skew_err,
  output logic                  busy
);

  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] lane_dat_in;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] tail_dat;
  logic [NUM_LANES-1:0]                 tail_vld;
  logic [NUM_LANES-1:0]                 lane_busy;

  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] out_dat_q, out_dat_d;
  logic                                 out_valid_q, out_valid_d;
  logic                                 frame_last_q, frame_last_d;
  logic                                 skew_err_q, skew_err_d;
  logic [CNT_W-1:0]                     beat_cnt_q, beat_cnt_d;
  align_e                               align;

  assign lane_dat_in[0] = line_0_in;
  assign lane_dat_in[1] = line_1_in;
  assign lane_dat_in[2] = line_2_in;
  assign lane_dat_in[3] = line_3_in;
  assign lane_dat_in[4] = line_4_in;

  generate
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      lane_delay_line #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (lane_depth(lane_idx_t'(k), WAVEFRONT_DELAY))
      ) u_delay (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_vld     (lane_valid_in[k]),
        .in_dat     (lane_dat_in[k]),
        .out_vld    (tail_vld[k]),
        .out_dat    (tail_dat[k]),
        .chain_busy (lane_busy[k])
      );
    end
  endgenerate

  // Set outranks clear so a misalignment in the clearing cycle is never lost.
  always_comb begin
    align        = classify(tail_vld);
    out_dat_d    = out_dat_q;
    out_valid_d  = 1'b0;
    frame_last_d = 1'b0;
    beat_cnt_d   = beat_cnt_q;
    skew_err_d   = skew_err_q;
    if (err_clr) begin
      skew_err_d = 1'b0;
    end
    case (align)
      ALIGN_BEAT: begin
        out_dat_d   = tail_dat;
        out_valid_d = 1'b1;
        if (beat_cnt_q == CNT_LAST) begin
          frame_last_d = 1'b1;
          beat_cnt_d   = '0;
        end else begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
      end
      ALIGN_SKEW: begin
        skew_err_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_dat_q    <= '0;
      out_valid_q  <= 1'b0;
      frame_last_q <= 1'b0;
      skew_err_q   <= 1'b0;
      beat_cnt_q   <= '0;
    end else begin
      out_dat_q    <= out_dat_d;
      out_valid_q  <= out_valid_d;
      frame_last_q <= frame_last_d;
      skew_err_q   <= skew_err_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  assign line_0_out = out_dat_q[0];
  assign line_1_out = out_dat_q[1];
  assign line_2_out = out_dat_q[2];
  assign line_3_out = out_dat_q[3];
  assign line_4_out = out_dat_q[4];
  assign out_valid  = out_valid_q;
  assign frame_last = frame_last_q;
  assign skew_err   = skew_err_q;
  assign busy       = (|lane_busy) | out_valid_q | (beat_cnt_q != '0);

endmodule

// File: tb/tb_wavefront_deskew.sv
// Directed bench: default instance (delay 4, frame 24) and a short one (delay 1, frame 2).
module tb_wavefront_deskew;

  localparam int PLAN = 96;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [4:0]      m_vld, s_vld;
  logic [4:0][7:0] m_li, s_li, m_lo, s_lo;
  logic            m_clr, s_clr;
  logic            m_ov, m_fl, m_err, m_busy;
  logic            s_ov, s_fl, s_err, s_busy;

  wavefront_deskew dut (
    .clk(clk), .rst_n(rst_n), .lane_valid_in(m_vld),
    .line_0_in(m_li[0]), .line_1_in(m_li[1]), .line_2_in(m_li[2]),
    .line_3_in(m_li[3]), .line_4_in(m_li[4]), .err_clr(m_clr),
    .line_0_out(m_lo[0]), .line_1_out(m_lo[1]), .line_2_out(m_lo[2]),
    .line_3_out(m_lo[3]), .line_4_out(m_lo[4]),
    .out_valid(m_ov), .frame_last(m_fl), .skew_err(m_err), .busy(m_busy)
  );

  wavefront_deskew #(.DATA_WIDTH(8), .WAVEFRONT_DELAY(1), .FRAME_LEN(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .lane_valid_in(s_vld),
    .line_0_in(s_li[0]), .line_1_in(s_li[1]), .line_2_in(s_li[2]),
    .line_3_in(s_li[3]), .line_4_in(s_li[4]), .err_clr(s_clr),
    .line_0_out(s_lo[0]), .line_1_out(s_lo[1]), .line_2_out(s_lo[2]),
    .line_3_out(s_lo[3]), .line_4_out(s_lo[4]),
    .out_valid(s_ov), .frame_last(s_fl), .skew_err(s_err), .busy(s_busy)
  );

  int errs   = 0;
  int checks = 0;

  logic [4:0]      pv [PLAN];
  logic [4:0][7:0] pd [PLAN];
  logic            pe [PLAN];
  logic            cv [PLAN+1];
  logic            cfl [PLAN+1];
  logic            cerr [PLAN+1];
  logic            cbusy [PLAN+1];
  logic [4:0][7:0] cd [PLAN+1];

  task automatic clear_plan;
    for (int c = 0; c < PLAN; c++) begin
      pv[c] = '0;
      pd[c] = '0;
      pe[c] = 1'b0;
    end
  endtask

  // Lane k of a wavefront starting at s enters at s+k*wd (+1 on the late lane).
  task automatic add_wave(input int s, input int wd, input logic [7:0] v0, input int late);
    for (int k = 0; k < 5; k++) begin
      int c;
      c = s + k * wd + ((k == late) ? 1 : 0);
      pv[c][k] = 1'b1;
      pd[c][k] = v0 + 8'(k);
    end
  endtask

  task automatic drive_idle;
    m_vld = '0; m_li = '0; m_clr = 1'b0;
    s_vld = '0; s_li = '0; s_clr = 1'b0;
  endtask

  // cap[c+1] holds outputs after the edge that samples plan cycle c.
  task automatic run_plan(input int n, input bit sel);
    for (int c = 0; c < n; c++) begin
      if (sel) begin
        s_vld = pv[c]; s_li = pd[c]; s_clr = pe[c];
      end else begin
        m_vld = pv[c]; m_li = pd[c]; m_clr = pe[c];
      end
      @(posedge clk);
      #1;
      cv[c+1]    = sel ? s_ov   : m_ov;
      cfl[c+1]   = sel ? s_fl   : m_fl;
      cerr[c+1]  = sel ? s_err  : m_err;
      cbusy[c+1] = sel ? s_busy : m_busy;
      cd[c+1]    = sel ? s_lo   : m_lo;
    end
    drive_idle();
  endtask

  task automatic do_reset;
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    int nv;
    do_reset();
    checks++; if (m_ov !== 1'b0) begin errs++; $display("FAIL rst_out_valid got %b want 0", m_ov); end
    checks++; if (m_busy !== 1'b0) begin errs++; $display("FAIL rst_busy got %b want 0", m_busy); end
    checks++; if (m_lo !== 40'h0) begin errs++; $display("FAIL rst_data got %h want 0", m_lo); end
    checks++; if (s_fl !== 1'b0 || s_err !== 1'b0) begin errs++; $display("FAIL rst_small_flags got %b%b want 00", s_fl, s_err); end
    clear_plan();
    add_wave(0, 4, 8'h10, -1);
    add_wave(10, 4, 8'h60, -1);
    run_plan(19, 1'b0);
    checks++; if (m_lo[2] !== 8'h12) begin errs++; $display("FAIL pre_rst_held got %h want 12", m_lo[2]); end
    checks++; if (m_busy !== 1'b1) begin errs++; $display("FAIL pre_rst_busy got %b want 1", m_busy); end
    rst_n = 1'b0;
    #2;
    checks++; if (m_lo !== 40'h0) begin errs++; $display("FAIL midrst_data got %h want 0", m_lo); end
    checks++; if (m_busy !== 1'b0 || m_ov !== 1'b0) begin errs++; $display("FAIL midrst_busy_valid got %b%b want 00", m_busy, m_ov); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_plan();
    run_plan(30, 1'b0);
    nv = 0;
    for (int c = 1; c <= 30; c++) if (cv[c] === 1'b1 || cerr[c] === 1'b1) nv++;
    checks++; if (nv != 0) begin errs++; $display("FAIL midrst_discard got %0d outputs want 0", nv); end
    checks++; if (cbusy[30] !== 1'b0) begin errs++; $display("FAIL midrst_idle_busy got %b want 0", cbusy[30]); end
  endtask

  task automatic test_single;
    do_reset();
    clear_plan();
    add_wave(0, 4, 8'h10, -1);
    run_plan(25, 1'b0);
    checks++; if (cv[16] !== 1'b0) begin errs++; $display("FAIL single_early got %b want 0", cv[16]); end
    checks++; if (cv[17] !== 1'b1) begin errs++; $display("FAIL single_valid17 got %b want 1", cv[17]); end
    checks++; if (cv[18] !== 1'b0) begin errs++; $display("FAIL single_pulse got %b want 0", cv[18]); end
    checks++; if (cd[17] !== 40'h14_13_12_11_10) begin errs++; $display("FAIL single_data got %h want 1413121110", cd[17]); end
    checks++; if (cerr[17] !== 1'b0 || cfl[17] !== 1'b0) begin errs++; $display("FAIL single_err_last got %b%b want 00", cerr[17], cfl[17]); end
    checks++; if (cbusy[5] !== 1'b1) begin errs++; $display("FAIL single_busy_flight got %b want 1", cbusy[5]); end
    checks++; if (cbusy[24] !== 1'b1) begin errs++; $display("FAIL single_busy_partial got %b want 1", cbusy[24]); end
  endtask

  task automatic test_streaming;
    do_reset();
    clear_plan();
    for (int s = 0; s < 24; s++) add_wave(s, 4, 8'(s), -1);
    run_plan(50, 1'b0);
    for (int c = 1; c <= 50; c++) begin
      logic ev, ef;
      ev = (c >= 17 && c <= 40);
      ef = (c == 40);
      checks++; if (cv[c] !== ev || cfl[c] !== ef) begin errs++; $display("FAIL stream_vl c=%0d got %b%b want %b%b", c, cv[c], cfl[c], ev, ef); end
      if (ev) begin
        checks++;
        if (cd[c][0] !== 8'(c - 17) || cd[c][4] !== 8'(c - 13)) begin
          errs++; $display("FAIL stream_data c=%0d got %h/%h want %h/%h", c, cd[c][0], cd[c][4], 8'(c - 17), 8'(c - 13));
        end
      end
    end
    checks++; if (cbusy[40] !== 1'b1) begin errs++; $display("FAIL stream_busy40 got %b want 1", cbusy[40]); end
    checks++; if (cbusy[41] !== 1'b0) begin errs++; $display("FAIL stream_busy41 got %b want 0", cbusy[41]); end
  endtask

  task automatic test_gapped;
    do_reset();
    clear_plan();
    for (int s = 0; s < 12; s++) add_wave(s, 4, 8'(s), -1);
    for (int s = 17; s < 29; s++) add_wave(s, 4, 8'(s - 5), -1);
    run_plan(50, 1'b0);
    for (int c = 1; c <= 50; c++) begin
      logic ev, ef;
      ev = (c >= 17 && c <= 28) || (c >= 34 && c <= 45);
      ef = (c == 45);
      checks++; if (cv[c] !== ev || cfl[c] !== ef) begin errs++; $display("FAIL gap_vl c=%0d got %b%b want %b%b", c, cv[c], cfl[c], ev, ef); end
    end
    checks++; if (cd[34][0] !== 8'd12) begin errs++; $display("FAIL gap_resume_data got %h want 0c", cd[34][0]); end
    checks++; if (cbusy[31] !== 1'b1) begin errs++; $display("FAIL gap_busy got %b want 1", cbusy[31]); end
  endtask

  task automatic test_misalign;
    int nv;
    do_reset();
    clear_plan();
    add_wave(0, 4, 8'h20, 3);
    add_wave(20, 4, 8'h30, -1);
    pe[40] = 1'b1;
    add_wave(45, 4, 8'h40, 3);
    pe[61] = 1'b1;
    run_plan(66, 1'b0);
    nv = 0;
    for (int c = 1; c <= 66; c++) if (cv[c] === 1'b1 && c != 37) nv++;
    checks++; if (nv != 0) begin errs++; $display("FAIL skew_dropped got %0d stray beats want 0", nv); end
    checks++; if (cv[37] !== 1'b1) begin errs++; $display("FAIL skew_good_beat got %b want 1", cv[37]); end
    checks++; if (cerr[16] !== 1'b0) begin errs++; $display("FAIL skew_err16 got %b want 0", cerr[16]); end
    checks++; if (cerr[17] !== 1'b1) begin errs++; $display("FAIL skew_err17 got %b want 1", cerr[17]); end
    checks++; if (cd[20] !== 40'h0) begin errs++; $display("FAIL skew_noload got %h want 0", cd[20]); end
    checks++; if (cerr[40] !== 1'b1) begin errs++; $display("FAIL skew_sticky got %b want 1", cerr[40]); end
    checks++; if (cd[38][3] !== 8'h33) begin errs++; $display("FAIL skew_hold got %h want 33", cd[38][3]); end
    checks++; if (cerr[41] !== 1'b0) begin errs++; $display("FAIL skew_clr got %b want 0", cerr[41]); end
    checks++; if (cerr[61] !== 1'b0) begin errs++; $display("FAIL skew_pre_coinc got %b want 0", cerr[61]); end
    checks++; if (cerr[62] !== 1'b1) begin errs++; $display("FAIL skew_set_wins got %b want 1", cerr[62]); end
  endtask

  task automatic test_small;
    do_reset();
    clear_plan();
    for (int s = 0; s < 4; s++) add_wave(s, 1, 8'(s * 16), -1);
    run_plan(12, 1'b1);
    for (int c = 1; c <= 12; c++) begin
      logic ev, ef;
      ev = (c >= 5 && c <= 8);
      ef = (c == 6 || c == 8);
      checks++; if (cv[c] !== ev || cfl[c] !== ef) begin errs++; $display("FAIL small_vl c=%0d got %b%b want %b%b", c, cv[c], cfl[c], ev, ef); end
    end
    checks++; if (cd[5] !== 40'h04_03_02_01_00) begin errs++; $display("FAIL small_data5 got %h want 0403020100", cd[5]); end
    checks++; if (cd[8][4] !== 8'h34) begin errs++; $display("FAIL small_data8 got %h want 34", cd[8][4]); end
    checks++; if (cerr[12] !== 1'b0 || cbusy[12] !== 1'b0) begin errs++; $display("FAIL small_end got %b%b want 00", cerr[12], cbusy[12]); end
  endtask

  initial begin
    drive_idle();
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_streaming();
    test_gapped();
    test_misalign();
    test_small();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
